// File: rtl/ir_fetch_sequencer.sv
// Instruction fetch controller: owns the PC, handshakes with instruction memory and
// drives the IR with a registered one-cycle load strobe plus void qualifier for flushes.
module ir_fetch_sequencer #(
  parameter int                ADDR_W       = 13,
  parameter int                INSTR_W      = 14,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                FLUSH_LOADS  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] ir_data,
  output logic               ir_load,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  ir_pc
);

  typedef enum logic [1:0] {S_FETCH, S_LOAD, S_FLUSH, S_GAP} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_LOADS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [2:0]        flush_cnt, flush_cnt_nxt;
  logic              accept;
  logic              load_nxt;

  assign imem_rd   = rst_n && (state == S_FETCH) && !stall;
  assign imem_addr = pc;
  assign accept    = imem_rd && imem_ready;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    flush_cnt_nxt = flush_cnt;
    if (branch_taken) begin
      pc_nxt        = branch_target;
      flush_cnt_nxt = FLUSH_INIT;
      // If a load pulse is high this cycle, insert a gap so the first void load is a fresh edge.
      state_nxt     = (state == S_LOAD || state == S_FLUSH) ? S_GAP : S_FLUSH;
    end else begin
      case (state)
        S_FETCH: begin
          if (accept) begin
            pc_nxt    = pc + 1'b1;
            state_nxt = S_LOAD;
          end
        end
        S_LOAD:  state_nxt = S_FETCH;
        S_FLUSH: begin
          flush_cnt_nxt = flush_cnt - 3'd1;
          state_nxt     = (flush_cnt_nxt == 3'd0) ? S_FETCH : S_GAP;
        end
        S_GAP:   state_nxt = S_FLUSH;
        default: state_nxt = S_FETCH;
      endcase
    end
    load_nxt = (state_nxt == S_LOAD) || (state_nxt == S_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= RESET_VECTOR;
      flush_cnt <= '0;
      ir_data   <= '0;
      ir_load   <= 1'b0;
      ir_valid  <= 1'b0;
      ir_pc     <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      flush_cnt <= flush_cnt_nxt;
      ir_load   <= load_nxt;
      if (branch_taken) begin
        ir_data  <= '0;
        ir_valid <= 1'b0;
      end else if (accept) begin
        ir_data  <= imem_data;
        ir_valid <= 1'b1;
        ir_pc    <= pc;
      end
    end
  end

endmodule
